adc_frame_builder: RTL and testbench

ADC_FRAME_BUILDER -- requirements
Module: adc_frame_builder

---
 rtl/encoder_fec_pkg.sv | 28 ++
 rtl/sample_packer.sv | 65 ++++++
 rtl/adc_frame_builder.sv | 115 +++++++++++
 tb/tb_adc_frame_builder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/encoder_fec_pkg.sv
// +-----------------------------------------------------------------------------+
// | encoder_fec_pkg : shared types and sizes for the ADC-to-encoder_fec path     |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

package encoder_fec_pkg;

   localparam int SAMPLE_W        = 8;
   localparam int SAMPLES_PER_MSG = 4;
   localparam int MSG_W           = SAMPLE_W * SAMPLES_PER_MSG;
   localparam int DROP_CNT_W      = 8;

   typedef logic [MSG_W-1:0] message_data_t;

   typedef enum logic [0:0] {
      OUT_IDLE = 1'b0,
      OUT_REQ  = 1'b1
   } out_state_t;

   // A counter over one slot still needs one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sample_packer.sv
// +-----------------------------------------------------------------------------+
// | sample_packer : packs ADC samples LSB-first into a frame, flags full frames  |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module sample_packer
   import encoder_fec_pkg::*;
#(
   parameter int SAMPLE_W        = encoder_fec_pkg::SAMPLE_W,
   parameter int SAMPLES_PER_MSG = encoder_fec_pkg::SAMPLES_PER_MSG
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                sample_valid,
   input  logic [SAMPLE_W-1:0]                 sample_in,
   input  logic                                out_busy,
   input  logic                                take,
   output logic                                frame_ready,
   output logic [SAMPLE_W*SAMPLES_PER_MSG-1:0] frame,
   output logic                                drop
);

   localparam int                 c_CNT_W = cnt_width(SAMPLES_PER_MSG);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(SAMPLES_PER_MSG - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic [SAMPLE_W*SAMPLES_PER_MSG-1:0] r_asm;
   logic [c_CNT_W-1:0]                  r_fill;
   logic                                r_ready;
   logic                                w_valid;
   logic                                w_accept;
   logic                                w_last;

   // A finished frame with the output still busy leaves nowhere to put a sample.
   assign w_valid  = en & sample_valid;
   assign drop     = w_valid & r_ready & out_busy;
   assign w_accept = w_valid & ~drop;
   assign w_last   = (r_fill == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_asm   <= '0;
         r_fill  <= '0;
         r_ready <= 1'b0;
      end else begin
         if (w_accept) begin
            r_asm[r_fill*SAMPLE_W +: SAMPLE_W] <= sample_in;
            r_fill <= w_last ? '0 : r_fill + c_ONE;
         end
         if (w_accept && w_last) begin
            r_ready <= 1'b1;
         end else if (take) begin
            r_ready <= 1'b0;
         end
      end
   end

   assign frame_ready = r_ready;
   assign frame       = r_asm;

endmodule

`default_nettype wire

// File: rtl/adc_frame_builder.sv
// +-----------------------------------------------------------------------------+
// | adc_frame_builder : ADC samples -> req/ack messages for encoder_fec          |
// | Optional drop counter output enabled by macro ADC_FRAME_DROP_CNT_EN          |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module adc_frame_builder
   import encoder_fec_pkg::*;
#(
   parameter int SAMPLE_W        = encoder_fec_pkg::SAMPLE_W,
   parameter int SAMPLES_PER_MSG = encoder_fec_pkg::SAMPLES_PER_MSG
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_in,
   output logic                req,
   output message_data_t       data_out,
   input  logic                ack,
   output logic                overflow
`ifdef ADC_FRAME_DROP_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   out_state_t    r_state;
   out_state_t    w_state_nxt;
   message_data_t r_data;
   message_data_t w_frame;
   logic          r_overflow;
   logic          w_take;
   logic          w_frame_ready;
   logic          w_drop;

   sample_packer #(
      .SAMPLE_W        (SAMPLE_W),
      .SAMPLES_PER_MSG (SAMPLES_PER_MSG)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .out_busy     (r_state == OUT_REQ),
      .take         (w_take),
      .frame_ready  (w_frame_ready),
      .frame        (w_frame),
      .drop         (w_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= OUT_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Leaving OUT_REQ always lands in OUT_IDLE, which guarantees a req-low gap.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      case (r_state)
         OUT_IDLE: begin
            if (w_frame_ready) begin
               w_state_nxt = OUT_REQ;
               w_take      = 1'b1;
            end
         end
         OUT_REQ: begin
            if (ack) begin
               w_state_nxt = OUT_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_take) begin
            r_data <= w_frame;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef ADC_FRAME_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != '1)) begin
         r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
   end

   assign drop_cnt = r_drop_cnt;
`endif

   assign req      = (r_state == OUT_REQ);
   assign data_out = r_data;
   assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_builder.sv
// +-----------------------------------------------------------------------------+
// | tb_adc_frame_builder : directed bench with message scoreboard                |
// | Rev 1.0 - initial release                                                    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_adc_frame_builder;
   import encoder_fec_pkg::*;

   logic          clk;
   logic          rst;
   logic          en;
   logic          sample_valid;
   logic [7:0]    sample_in;
   logic          req;
   message_data_t data_out;
   logic          ack;
   logic          overflow;
`ifdef ADC_FRAME_DROP_CNT_EN
   logic [7:0]    drop_cnt;
`endif

   int            n_tests = 0;
   int            n_fail  = 0;
   message_data_t sb[$];
   logic          prev_req  = 1'b0;
   message_data_t prev_data = '0;

   adc_frame_builder dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .req          (req),
      .data_out     (data_out),
      .ack          (ack),
      .overflow     (overflow)
`ifdef ADC_FRAME_DROP_CNT_EN
      ,
      .drop_cnt     (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic e, input logic v, input logic [7:0] s, input logic a);
      en           = e;
      sample_valid = v;
      sample_in    = s;
      ack          = a;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      ack          = 1'b0;
   endtask

   task automatic frame4(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3);
      sb.push_back({s3, s2, s1, s0});
      cyc(1'b1, 1'b1, s0, 1'b0);
      cyc(1'b1, 1'b1, s1, 1'b0);
      cyc(1'b1, 1'b1, s2, 1'b0);
      cyc(1'b1, 1'b1, s3, 1'b0);
   endtask

   // Each new req must carry the oldest outstanding frame; data must hold while req stays high.
   always @(posedge clk) begin
      #1;
      if (req && !prev_req) begin
         chk("sb_pending", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) chk("frame", data_out, sb.pop_front());
      end else if (req && prev_req) begin
         chk("hold", data_out, prev_data);
      end
      prev_req  = req;
      prev_data = data_out;
   end

   initial begin
      rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = '0; ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_data", data_out, 32'h0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;

      // basic packing and 2-edge latency
      frame4(8'h11, 8'h22, 8'h33, 8'h44);
      chk("lat_edge1_req", 32'(req), 32'd0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("lat_edge2_req", 32'(req), 32'd1);
      chk("basic_data", data_out, 32'h44332211);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("no_ack_req", 32'(req), 32'd1);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      chk("ack_req_low", 32'(req), 32'd0);

      // overflow: two frames outstanding, next sample dropped
      frame4(8'h51, 8'h52, 8'h53, 8'h54);
      frame4(8'h55, 8'h56, 8'h57, 8'h58);
      chk("ovf_before", 32'(overflow), 32'd0);
      cyc(1'b1, 1'b1, 8'h99, 1'b0);
      chk("ovf_set", 32'(overflow), 32'd1);
`ifdef ADC_FRAME_DROP_CNT_EN
      chk("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif
      chk("ovf_held_data", data_out, 32'h54535251);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      chk("ovf_gap_req", 32'(req), 32'd0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("ovf_next_req", 32'(req), 32'd1);
      chk("ovf_next_data", data_out, 32'h58575655);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);

      // last sample of B together with ack of A; transfer-edge sample starts C
      frame4(8'hC1, 8'hC2, 8'hC3, 8'hC4);
      sb.push_back(32'hD4D3D2D1);
      sb.push_back(32'hE4E3E2E1);
      cyc(1'b1, 1'b1, 8'hD1, 1'b0);
      cyc(1'b1, 1'b1, 8'hD2, 1'b0);
      cyc(1'b1, 1'b1, 8'hD3, 1'b0);
      cyc(1'b1, 1'b1, 8'hD4, 1'b1);
      chk("sim_gap_req", 32'(req), 32'd0);
      cyc(1'b1, 1'b1, 8'hE1, 1'b0);
      chk("sim_b_req", 32'(req), 32'd1);
      chk("sim_b_data", data_out, 32'hD4D3D2D1);
      cyc(1'b1, 1'b1, 8'hE2, 1'b1);
      cyc(1'b1, 1'b1, 8'hE3, 1'b0);
      cyc(1'b1, 1'b1, 8'hE4, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("sim_c_data", data_out, 32'hE4E3E2E1);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);

      // reset mid-frame
      cyc(1'b1, 1'b1, 8'hF1, 1'b0);
      cyc(1'b1, 1'b1, 8'hF2, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ovf", 32'(overflow), 32'd0);
      chk("async_rst_data", data_out, 32'h0);
      #1 rst = 1'b0;
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("post_rst_req", 32'(req), 32'd0);
`ifdef ADC_FRAME_DROP_CNT_EN
      chk("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
      frame4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("rst_frame_data", data_out, 32'hA4A3A2A1);
      chk("rst_frame_ovf", 32'(overflow), 32'd0);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);

      // enable gating
      cyc(1'b1, 1'b1, 8'h05, 1'b0);
      cyc(1'b1, 1'b1, 8'h06, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'hEE, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0);
      chk("en_off_req", 32'(req), 32'd0);
      sb.push_back(32'h02010605);
      cyc(1'b1, 1'b1, 8'h01, 1'b0);
      cyc(1'b1, 1'b1, 8'h02, 1'b0);
      cyc(1'b1, 1'b1, 8'h03, 1'b0);
      cyc(1'b1, 1'b1, 8'h04, 1'b0);
      chk("en_data", data_out, 32'h02010605);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);

      // drop-counter saturation
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      frame4(8'h31, 8'h32, 8'h33, 8'h34);
      frame4(8'h35, 8'h36, 8'h37, 8'h38);
      for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
      chk("sat_ovf", 32'(overflow), 32'd1);
`ifdef ADC_FRAME_DROP_CNT_EN
      chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
`endif
      chk("sat_held_data", data_out, 32'h34333231);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("sat_next_data", data_out, 32'h38373635);
      cyc(1'b1, 1'b0, 8'h00, 1'b1);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
